// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Instruction-decode stage of a five-stage MIPS-style pipeline.
//               Holds the IF/ID pipeline register, the 32x32 register file,
//               the main/ALU control decoder and the early branch/jump
//               resolution logic that redirects fetch.
//
// Ports
//   i_CLK, i_RST          : clock (rising edge) and synchronous active-high reset
//   i_InstrF, i_PCPlus4F  : instruction and PC+4 from the fetch stage
//   i_StallD, i_FlushD    : hazard-unit hold / clear of the IF/ID register
//   i_RegWriteW,
//   i_WriteRegW, i_ResultW: register-file writeback port
//   i_ALUOutM,
//   i_ForwardAD/BD        : forwarding of the memory-stage ALU result into
//                           the branch comparator
//   o_PCNextD, o_PCSrcD,
//   o_JumpD, o_LoadD      : redirect to fetch (combinational from IF/ID)
//   o_RD1D, o_RD2D        : unforwarded register-file read data
//   o_ImmExtD             : sign-extended 16-bit immediate
//   o_RsD, o_RtD, o_RdD   : register specifiers
//   o_RegWriteD ...
//   o_ALUControlD         : control signals for the downstream stages
//
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,

    input  logic [INSTR_WIDTH-1:0]   i_InstrF,
    input  logic [ADDRESS_WIDTH-1:0] i_PCPlus4F,

    input  logic                     i_StallD,
    input  logic                     i_FlushD,

    input  logic                     i_RegWriteW,
    input  logic [4:0]               i_WriteRegW,
    input  logic [31:0]              i_ResultW,

    input  logic [31:0]              i_ALUOutM,
    input  logic                     i_ForwardAD,
    input  logic                     i_ForwardBD,

    output logic [ADDRESS_WIDTH-1:0] o_PCNextD,
    output logic                     o_PCSrcD,
    output logic                     o_JumpD,
    output logic                     o_LoadD,

    output logic [31:0]              o_RD1D,
    output logic [31:0]              o_RD2D,
    output logic [31:0]              o_ImmExtD,
    output logic [4:0]               o_RsD,
    output logic [4:0]               o_RtD,
    output logic [4:0]               o_RdD,

    output logic                     o_RegWriteD,
    output logic                     o_MemtoRegD,
    output logic                     o_MemWriteD,
    output logic                     o_ALUSrcD,
    output logic                     o_RegDstD,
    output logic                     o_BranchD,
    output logic [2:0]               o_ALUControlD
);

    // ------------------------------------------------------------------
    // Opcode / funct encodings
    // ------------------------------------------------------------------
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;

    localparam logic [2:0] c_ALU_AND  = 3'b000;
    localparam logic [2:0] c_ALU_OR   = 3'b001;
    localparam logic [2:0] c_ALU_ADD  = 3'b010;
    localparam logic [2:0] c_ALU_SUB  = 3'b110;
    localparam logic [2:0] c_ALU_SLT  = 3'b111;

    // ------------------------------------------------------------------
    // IF/ID pipeline register
    // Stall has priority over flush so that a held instruction is never
    // lost when the hazard unit raises both in the same cycle.
    // ------------------------------------------------------------------
    logic [INSTR_WIDTH-1:0]   r_instr_d;
    logic [ADDRESS_WIDTH-1:0] r_pcplus4_d;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_instr_d   <= '0;
            r_pcplus4_d <= '0;
        end else if (i_StallD) begin
            r_instr_d   <= r_instr_d;
            r_pcplus4_d <= r_pcplus4_d;
        end else if (i_FlushD) begin
            r_instr_d   <= '0;
            r_pcplus4_d <= '0;
        end else begin
            r_instr_d   <= i_InstrF;
            r_pcplus4_d <= i_PCPlus4F;
        end
    end

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [25:0] w_jidx;
    logic [31:0] w_imm_ext;

    assign w_opcode  = r_instr_d[31:26];
    assign w_rs      = r_instr_d[25:21];
    assign w_rt      = r_instr_d[20:16];
    assign w_rd      = r_instr_d[15:11];
    assign w_funct   = r_instr_d[5:0];
    assign w_jidx    = r_instr_d[25:0];
    assign w_imm_ext = {{16{r_instr_d[15]}}, r_instr_d[15:0]};

    // ------------------------------------------------------------------
    // Register file: 32 x 32, register 0 hard-wired to zero.
    // Reset wins over a coincident writeback, so that write is dropped.
    // ------------------------------------------------------------------
    logic [31:0] r_regs [32];

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_RegWriteW && (i_WriteRegW != 5'd0)) begin
            r_regs[i_WriteRegW] <= i_ResultW;
        end
    end

    // Combinational reads with write-through: an instruction in decode sees
    // the value being written back in the same cycle, which removes the
    // WB->ID hazard without a half-cycle register file.
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;

    always_comb begin
        w_rd1 = r_regs[w_rs];
        if (w_rs == 5'd0) begin
            w_rd1 = '0;
        end else if (i_RegWriteW && (i_WriteRegW == w_rs)) begin
            w_rd1 = i_ResultW;
        end
    end

    always_comb begin
        w_rd2 = r_regs[w_rt];
        if (w_rt == 5'd0) begin
            w_rd2 = '0;
        end else if (i_RegWriteW && (i_WriteRegW == w_rt)) begin
            w_rd2 = i_ResultW;
        end
    end

    // ------------------------------------------------------------------
    // Main and ALU control decoder
    // ------------------------------------------------------------------
    logic       w_reg_write;
    logic       w_mem_to_reg;
    logic       w_mem_write;
    logic       w_alu_src;
    logic       w_reg_dst;
    logic       w_branch;
    logic       w_branch_ne;
    logic       w_jump;
    logic [2:0] w_alu_ctrl;

    always_comb begin
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_mem_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_reg_dst    = 1'b0;
        w_branch     = 1'b0;
        w_branch_ne  = 1'b0;
        w_jump       = 1'b0;
        w_alu_ctrl   = c_ALU_AND;

        case (w_opcode)
            c_OP_RTYPE: begin
                // Unsupported funct codes fall through as a full nop.
                case (w_funct)
                    c_FN_ADD: begin
                        w_reg_write = 1'b1;
                        w_reg_dst   = 1'b1;
                        w_alu_ctrl  = c_ALU_ADD;
                    end
                    c_FN_SUB: begin
                        w_reg_write = 1'b1;
                        w_reg_dst   = 1'b1;
                        w_alu_ctrl  = c_ALU_SUB;
                    end
                    c_FN_AND: begin
                        w_reg_write = 1'b1;
                        w_reg_dst   = 1'b1;
                        w_alu_ctrl  = c_ALU_AND;
                    end
                    c_FN_OR: begin
                        w_reg_write = 1'b1;
                        w_reg_dst   = 1'b1;
                        w_alu_ctrl  = c_ALU_OR;
                    end
                    c_FN_SLT: begin
                        w_reg_write = 1'b1;
                        w_reg_dst   = 1'b1;
                        w_alu_ctrl  = c_ALU_SLT;
                    end
                    default: ;
                endcase
            end
            c_OP_LW: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_alu_src    = 1'b1;
                w_alu_ctrl   = c_ALU_ADD;
            end
            c_OP_SW: begin
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
                w_alu_ctrl  = c_ALU_ADD;
            end
            c_OP_ADDI: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_alu_ctrl  = c_ALU_ADD;
            end
            c_OP_BEQ: begin
                w_branch   = 1'b1;
                w_alu_ctrl = c_ALU_SUB;
            end
            c_OP_BNE: begin
                w_branch    = 1'b1;
                w_branch_ne = 1'b1;
                w_alu_ctrl  = c_ALU_SUB;
            end
            c_OP_J: begin
                w_jump = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Early branch resolution and next-PC selection.
    // Everything below is combinational from IF/ID so a redirect reaches
    // fetch in the same cycle the branch/jump sits in decode.
    // ------------------------------------------------------------------
    logic [31:0]              w_cmp_a;
    logic [31:0]              w_cmp_b;
    logic                     w_equal;
    logic                     w_taken;
    logic [31:0]              w_imm_sl2;
    logic [ADDRESS_WIDTH-1:0] w_branch_target;
    logic [ADDRESS_WIDTH-1:0] w_jump_target;

    assign w_cmp_a   = i_ForwardAD ? i_ALUOutM : w_rd1;
    assign w_cmp_b   = i_ForwardBD ? i_ALUOutM : w_rd2;
    assign w_equal   = (w_cmp_a == w_cmp_b);
    assign w_taken   = w_branch & (w_branch_ne ? ~w_equal : w_equal);

    // Offset is word-scaled; the add wraps naturally at the address width.
    assign w_imm_sl2       = {w_imm_ext[29:0], 2'b00};
    assign w_branch_target = r_pcplus4_d + w_imm_sl2[ADDRESS_WIDTH-1:0];

    // Pseudo-direct jump keeps the upper region bits of PC+4.
    assign w_jump_target   = {r_pcplus4_d[ADDRESS_WIDTH-1:28], w_jidx, 2'b00};

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_PCSrcD      = w_taken | w_jump;
    assign o_JumpD       = w_jump;
    assign o_LoadD       = o_PCSrcD;
    assign o_PCNextD     = w_jump ? w_jump_target : w_branch_target;

    assign o_RD1D        = w_rd1;
    assign o_RD2D        = w_rd2;
    assign o_ImmExtD     = w_imm_ext;
    assign o_RsD         = w_rs;
    assign o_RtD         = w_rt;
    assign o_RdD         = w_rd;

    assign o_RegWriteD   = w_reg_write;
    assign o_MemtoRegD   = w_mem_to_reg;
    assign o_MemWriteD   = w_mem_write;
    assign o_ALUSrcD     = w_alu_src;
    assign o_RegDstD     = w_reg_dst;
    assign o_BranchD     = w_branch;
    assign o_ALUControlD = w_alu_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed self-checking bench for decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instr_f;
    logic [31:0] pcplus4_f;
    logic        stall_d;
    logic        flush_d;
    logic        reg_write_w;
    logic [4:0]  write_reg_w;
    logic [31:0] result_w;
    logic [31:0] alu_out_m;
    logic        fwd_a;
    logic        fwd_b;

    logic [31:0] pc_next_d;
    logic        pc_src_d;
    logic        jump_d;
    logic        load_d;
    logic [31:0] rd1_d;
    logic [31:0] rd2_d;
    logic [31:0] imm_ext_d;
    logic [4:0]  rs_d;
    logic [4:0]  rt_d;
    logic [4:0]  rd_d;
    logic        reg_write_d;
    logic        mem_to_reg_d;
    logic        mem_write_d;
    logic        alu_src_d;
    logic        reg_dst_d;
    logic        branch_d;
    logic [2:0]  alu_ctrl_d;

    int checks;
    int errors;

    decode_stage #(
        .ADDRESS_WIDTH (32),
        .INSTR_WIDTH   (32)
    ) dut (
        .i_CLK         (clk),
        .i_RST         (rst),
        .i_InstrF      (instr_f),
        .i_PCPlus4F    (pcplus4_f),
        .i_StallD      (stall_d),
        .i_FlushD      (flush_d),
        .i_RegWriteW   (reg_write_w),
        .i_WriteRegW   (write_reg_w),
        .i_ResultW     (result_w),
        .i_ALUOutM     (alu_out_m),
        .i_ForwardAD   (fwd_a),
        .i_ForwardBD   (fwd_b),
        .o_PCNextD     (pc_next_d),
        .o_PCSrcD      (pc_src_d),
        .o_JumpD       (jump_d),
        .o_LoadD       (load_d),
        .o_RD1D        (rd1_d),
        .o_RD2D        (rd2_d),
        .o_ImmExtD     (imm_ext_d),
        .o_RsD         (rs_d),
        .o_RtD         (rt_d),
        .o_RdD         (rd_d),
        .o_RegWriteD   (reg_write_d),
        .o_MemtoRegD   (mem_to_reg_d),
        .o_MemWriteD   (mem_write_d),
        .o_ALUSrcD     (alu_src_d),
        .o_RegDstD     (reg_dst_d),
        .o_BranchD     (branch_d),
        .o_ALUControlD (alu_ctrl_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bundle {RegWrite,MemtoReg,MemWrite,ALUSrc,RegDst,Branch,ALU[2:0]}
    logic [8:0] ctrl;
    assign ctrl = {reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d,
                   reg_dst_d, branch_d, alu_ctrl_d};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Table of instruction -> expected control bundle
    logic [31:0] tbl_instr [9];
    logic [8:0]  tbl_ctrl  [9];

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        instr_f     = 32'hDEAD_BEEF;
        pcplus4_f   = 32'h1234_5678;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        reg_write_w = 1'b0;
        write_reg_w = 5'd0;
        result_w    = 32'd0;
        alu_out_m   = 32'd0;
        fwd_a       = 1'b0;
        fwd_b       = 1'b0;

        // ---------------- reset ----------------
        step();
        step();
        chk("rst_ctrl",   {23'd0, ctrl}, 32'd0);
        chk("rst_pcsrc",  {31'd0, pc_src_d}, 32'd0);
        chk("rst_jump",   {31'd0, jump_d}, 32'd0);
        chk("rst_load",   {31'd0, load_d}, 32'd0);
        chk("rst_rd1",    rd1_d, 32'd0);

        // ---------------- lw $8,4($0) ----------------
        rst       = 1'b0;
        instr_f   = 32'h8C08_0004;
        pcplus4_f = 32'h0000_0004;
        step();
        chk("lw_ctrl",    {23'd0, ctrl}, {23'd0, 9'b1_1_0_1_0_0_010});
        chk("lw_rt",      {27'd0, rt_d}, 32'd8);
        chk("lw_imm",     imm_ext_d, 32'd4);
        chk("lw_pcsrc",   {31'd0, pc_src_d}, 32'd0);

        // ---------------- write $9=0x55, beq $9,$9,+3 ----------------
        reg_write_w = 1'b1;
        write_reg_w = 5'd9;
        result_w    = 32'h55;
        instr_f     = 32'h1129_0003;
        pcplus4_f   = 32'h0000_0100;
        step();
        reg_write_w = 1'b0;
        #1;
        chk("beq_rd1",    rd1_d, 32'h55);
        chk("beq_rd2",    rd2_d, 32'h55);
        chk("beq_ctrl",   {23'd0, ctrl}, {23'd0, 9'b0_0_0_0_0_1_110});
        chk("beq_pcsrc",  {31'd0, pc_src_d}, 32'd1);
        chk("beq_load",   {31'd0, load_d}, 32'd1);
        chk("beq_next",   pc_next_d, 32'h0000_010C);
        chk("beq_jump",   {31'd0, jump_d}, 32'd0);

        // ---------------- bne $9,$0 with forwarding ----------------
        instr_f   = 32'h1520_0005;
        pcplus4_f = 32'h0000_0200;
        step();
        fwd_a     = 1'b1;
        alu_out_m = 32'h0;
        #1;
        chk("bne_fwd_pcsrc", {31'd0, pc_src_d}, 32'd0);
        chk("bne_fwd_rd1",   rd1_d, 32'h55);
        fwd_a = 1'b0;
        #1;
        chk("bne_nofwd_pcsrc", {31'd0, pc_src_d}, 32'd1);
        chk("bne_nofwd_next",  pc_next_d, 32'h0000_0214);
        fwd_b     = 1'b1;
        alu_out_m = 32'h55;
        #1;
        chk("bne_fwdb_pcsrc",  {31'd0, pc_src_d}, 32'd0);
        fwd_b     = 1'b0;
        alu_out_m = 32'h0;

        // ---------------- beq $0,$0,-4 with wrap ----------------
        instr_f   = 32'h1000_FFFC;
        pcplus4_f = 32'h0000_0004;
        step();
        chk("beq_neg_imm",   imm_ext_d, 32'hFFFF_FFFC);
        chk("beq_neg_next",  pc_next_d, 32'hFFFF_FFF4);
        chk("beq_neg_pcsrc", {31'd0, pc_src_d}, 32'd1);

        // ---------------- j 0x40 ----------------
        instr_f   = 32'h0800_0040;
        pcplus4_f = 32'hF000_0004;
        step();
        chk("j_jump",   {31'd0, jump_d}, 32'd1);
        chk("j_next",   pc_next_d, 32'hF000_0100);
        chk("j_pcsrc",  {31'd0, pc_src_d}, 32'd1);
        chk("j_ctrl",   {23'd0, ctrl}, 32'd0);

        // ---------------- stall + flush: hold; write $10 meanwhile ----------------
        stall_d     = 1'b1;
        flush_d     = 1'b1;
        instr_f     = 32'h8C08_0004;
        pcplus4_f   = 32'h0000_0040;
        reg_write_w = 1'b1;
        write_reg_w = 5'd10;
        result_w    = 32'h77;
        step();
        reg_write_w = 1'b0;
        #1;
        chk("stall_jump", {31'd0, jump_d}, 32'd1);
        chk("stall_next", pc_next_d, 32'hF000_0100);
        chk("stall_ctrl", {23'd0, ctrl}, 32'd0);

        // ---------------- flush alone ----------------
        stall_d = 1'b0;
        step();
        chk("flush_jump",  {31'd0, jump_d}, 32'd0);
        chk("flush_pcsrc", {31'd0, pc_src_d}, 32'd0);
        chk("flush_ctrl",  {23'd0, ctrl}, 32'd0);
        chk("flush_imm",   imm_ext_d, 32'd0);
        flush_d = 1'b0;

        // ---------------- write $0 ignored; add $3,$0,$10 ----------------
        reg_write_w = 1'b1;
        write_reg_w = 5'd0;
        result_w    = 32'hFFFF;
        instr_f     = 32'h000A_1820;
        pcplus4_f   = 32'h0000_0008;
        step();
        chk("r0_rd1",   rd1_d, 32'd0);
        chk("r10_rd2",  rd2_d, 32'h77);
        chk("add_ctrl", {23'd0, ctrl}, {23'd0, 9'b1_0_0_0_1_0_010});
        chk("add_rd",   {27'd0, rd_d}, 32'd3);
        reg_write_w = 1'b0;
        #1;
        chk("r0_rd1_after", rd1_d, 32'd0);

        // ---------------- same-cycle write-through $5=0xAB ----------------
        instr_f   = 32'h00A0_1820;
        pcplus4_f = 32'h0000_000C;
        step();
        chk("r5_before", rd1_d, 32'd0);
        reg_write_w = 1'b1;
        write_reg_w = 5'd5;
        result_w    = 32'hAB;
        #1;
        chk("r5_bypass", rd1_d, 32'hAB);
        step();
        reg_write_w = 1'b0;
        #1;
        chk("r5_stored", rd1_d, 32'hAB);

        // ---------------- control decode table ----------------
        tbl_instr[0] = 32'h00A0_1822; tbl_ctrl[0] = 9'b1_0_0_0_1_0_110; // sub
        tbl_instr[1] = 32'h00A0_1824; tbl_ctrl[1] = 9'b1_0_0_0_1_0_000; // and
        tbl_instr[2] = 32'h00A0_1825; tbl_ctrl[2] = 9'b1_0_0_0_1_0_001; // or
        tbl_instr[3] = 32'h00A0_182A; tbl_ctrl[3] = 9'b1_0_0_0_1_0_111; // slt
        tbl_instr[4] = 32'h00A0_1800; tbl_ctrl[4] = 9'b0_0_0_0_0_0_000; // bad funct
        tbl_instr[5] = 32'hAC08_0010; tbl_ctrl[5] = 9'b0_0_1_1_0_0_010; // sw
        tbl_instr[6] = 32'h2008_0010; tbl_ctrl[6] = 9'b1_0_0_1_0_0_010; // addi
        tbl_instr[7] = 32'hFC08_0010; tbl_ctrl[7] = 9'b0_0_0_0_0_0_000; // bad op
        tbl_instr[8] = 32'h3C08_0010; tbl_ctrl[8] = 9'b0_0_0_0_0_0_000; // lui: unsupported
        for (int k = 0; k < 9; k++) begin
            instr_f = tbl_instr[k];
            step();
            chk($sformatf("tbl_ctrl_%0d", k), {23'd0, ctrl}, {23'd0, tbl_ctrl[k]});
            chk($sformatf("tbl_pcsrc_%0d", k), {31'd0, pc_src_d}, 32'd0);
        end

        // ---------------- reset mid-stall discards writeback ----------------
        instr_f     = 32'h0800_0040;
        pcplus4_f   = 32'hF000_0004;
        step();
        stall_d     = 1'b1;
        rst         = 1'b1;
        reg_write_w = 1'b1;
        write_reg_w = 5'd5;
        result_w    = 32'h123;
        step();
        reg_write_w = 1'b0;
        rst         = 1'b0;
        stall_d     = 1'b0;
        #1;
        chk("rst_stall_jump", {31'd0, jump_d}, 32'd0);
        chk("rst_stall_ctrl", {23'd0, ctrl}, 32'd0);
        instr_f = 32'h00A9_1820; // add $3,$5,$9
        step();
        chk("rst_r5", rd1_d, 32'd0);
        chk("rst_r9", rd2_d, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
